alu_ctrl_pipe: RTL and testbench
================================

Name: alu_ctrl_pipe

Overview:
Registered, handshaked successor to the combinational ALU control decoder. It accepts an (ALUop, FuncCode) pair and emits the 4-bit ALU control word after one register stage. It sits between instruction decode and the ALU. It adds parametrised widths, full R-type decoding, illegal-function flagging, and a multi-cycle hold for MUL/DIV so the ALU sees a stable control word for the whole operation.

Parameters:
OP_W, 4, width of alu_op
FUNC_W, 6, width of func_code (R-type function field)
CTRL_W, 4, width of alu_ctrl; must be >= 4
RTYPE_OP, 4'b1111, alu_op value that selects func_code decoding
MUL_CYCLES, 4, cycles from accept to out_valid for MUL; must be >= 1
DIV_CYCLES, 8, cycles from accept to out_valid for DIV; must be >= 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream request valid
in_ready  out  1  block can accept this cycle
alu_op  in  OP_W  main-control ALU op
func_code  in  FUNC_W  instruction function field
out_valid  out  1  alu_ctrl valid for the ALU
out_ready  in  1  ALU consumes alu_ctrl this cycle
alu_ctrl  out  CTRL_W  control word to the ALU
busy  out  1  multi-cycle op in progress
illegal  out  1  registered with alu_ctrl; high = unknown func_code

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is synchronous and active-low.
  - While rst_n=0 at a clk edge: state=IDLE, out_valid=0, alu_ctrl=NOP, illegal=0, busy=0, counter=0.
  - Reset mid-operation, including WAIT, discards the op with no output.
- Decode (combinational, from the inputs at accept):
  - If alu_op==RTYPE_OP, decode func_code:
    - 100000 → ADD
    - 100010 → SUB
    - 100001 → ADDU
    - 100011 → SUBU
    - 100100 → AND
    - 100101 → OR
    - 101010 → SLT
    - 011000 → MUL
    - 011010 → DIV
    - 000000 → NOP
    - any other value → NOP with illegal=1.
  - Else alu_ctrl_next = alu_op[3:0], zero-extended to CTRL_W, with illegal=0. alu_op==RTYPE_OP never reaches this path.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Transfer occurs when out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==OUT && out_ready). A new op may be accepted in the same cycle the held one is consumed.
- State machine:
  - IDLE:
    - accept non-MUL/DIV → OUT.
    - accept MUL → WAIT with counter=MUL_CYCLES-1.
    - accept DIV → WAIT with counter=DIV_CYCLES-1.
    - If the loaded counter is 0, go straight to OUT.
  - WAIT:
    - out_valid=0, busy=1, alu_ctrl holds MUL/DIV code.
    - counter decrements each cycle; at counter==1 the next state is OUT.
    - in_ready=0.
  - OUT:
    - out_valid=1, busy=0.
    - transfer with no accept → IDLE.
    - transfer with accept → load the new op as in IDLE.
    - no transfer → hold alu_ctrl and illegal stable.
- Latency:
  - Single-cycle ops: out_valid in the cycle after accept.
  - MUL: out_valid exactly MUL_CYCLES cycles after the accept edge.
  - DIV: out_valid exactly DIV_CYCLES cycles after the accept edge.
- Stability: alu_ctrl and illegal change only on a loading edge (accept). They hold otherwise, including under backpressure.
- Illegal func_code: still traverses as NOP with illegal=1. It is not dropped.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - CTRL code constants: ADD=0000, SUB=0001, ADDU=0010, SUBU=0011, AND=0100, OR=0101, SLT=0110, MUL=0111, DIV=1000, NOP=1111.
  - FUNC code constants.
  - State enum {IDLE, WAIT, OUT}.
- Natural sub-module: alu_func_decode, a pure combinational func_code→{ctrl, illegal, multi-cycle kind} decoder, reused by the hazard unit.
- The top holds the FSM, counter and output register.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, alu_ctrl=1111, busy=0, in_ready=1 after release.
- alu_op=1111, func=100010, out_ready=1 → alu_ctrl=0001 and out_valid=1 one cycle after accept. Back-to-back ADD/SUB/AND at full rate gives one result per cycle.
- alu_op=0101 (non-R) → alu_ctrl=0101, illegal=0. Then func=111111 with R-type → alu_ctrl=1111, illegal=1.
- MUL with MUL_CYCLES=4 → busy=1 and in_ready=0 for 3 cycles, out_valid on the 4th cycle. DIV with DIV_CYCLES=8 → out_valid 8 cycles after accept.
- Backpressure: out_ready=0 for 5 cycles after an ADD → alu_ctrl stable at 0000, in_ready=0. Then out_ready=1 with a SUB pending → SUB accepted the same cycle and appears next cycle.
- Reset asserted in the 2nd WAIT cycle of a DIV → next cycle IDLE, out_valid never asserts for that DIV.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the registered ALU control decoder.
// Contents:
//   - CTRL_*  : 4-bit ALU control codes driven towards the ALU
//   - FUNC_*  : 6-bit R-type function field encodings
//   - state_e : control FSM states
//   - mc_kind_e : multi-cycle operation class produced by the decoder
//   - cnt_width : counter width needed to hold a cycle count
package alu_ctrl_pkg;

  localparam logic [3:0] CTRL_ADD  = 4'b0000;
  localparam logic [3:0] CTRL_SUB  = 4'b0001;
  localparam logic [3:0] CTRL_ADDU = 4'b0010;
  localparam logic [3:0] CTRL_SUBU = 4'b0011;
  localparam logic [3:0] CTRL_AND  = 4'b0100;
  localparam logic [3:0] CTRL_OR   = 4'b0101;
  localparam logic [3:0] CTRL_SLT  = 4'b0110;
  localparam logic [3:0] CTRL_MUL  = 4'b0111;
  localparam logic [3:0] CTRL_DIV  = 4'b1000;
  localparam logic [3:0] CTRL_NOP  = 4'b1111;

  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_MUL  = 6'b011000;
  localparam logic [5:0] FUNC_DIV  = 6'b011010;
  localparam logic [5:0] FUNC_NOP  = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MC_NONE = 2'd0,
    MC_MUL  = 2'd1,
    MC_DIV  = 2'd2
  } mc_kind_e;

  // Bits needed to represent values 0..n (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) <= n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// Pure combinational decoder of the R-type function field.
// Ports:
//   i_func    : function field of the instruction
//   o_ctrl    : 4-bit ALU control code (NOP for unknown encodings)
//   o_illegal : high when i_func is not a known encoding
//   o_kind    : multi-cycle class (none / MUL / DIV)
// Kept free of state so other units (e.g. hazard detection) can reuse it.
module alu_func_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned FUNC_W = 6
) (
  input  logic [FUNC_W-1:0] i_func,
  output logic [3:0]        o_ctrl,
  output logic              o_illegal,
  output mc_kind_e          o_kind
);

  logic       w_upper_zero;
  logic [5:0] w_func6;

  assign w_func6 = i_func[5:0];

  // A wider function field is only legal when its extra bits are zero.
  if (FUNC_W > 6) begin : g_upper
    assign w_upper_zero = (i_func[FUNC_W-1:6] == '0);
  end else begin : g_no_upper
    assign w_upper_zero = 1'b1;
  end

  // Table lookup of the function field.
  always_comb begin
    o_ctrl    = CTRL_NOP;
    o_illegal = 1'b0;
    o_kind    = MC_NONE;
    if (w_upper_zero) begin
      case (w_func6)
        FUNC_ADD:  o_ctrl = CTRL_ADD;
        FUNC_SUB:  o_ctrl = CTRL_SUB;
        FUNC_ADDU: o_ctrl = CTRL_ADDU;
        FUNC_SUBU: o_ctrl = CTRL_SUBU;
        FUNC_AND:  o_ctrl = CTRL_AND;
        FUNC_OR:   o_ctrl = CTRL_OR;
        FUNC_SLT:  o_ctrl = CTRL_SLT;
        FUNC_MUL: begin
          o_ctrl = CTRL_MUL;
          o_kind = MC_MUL;
        end
        FUNC_DIV: begin
          o_ctrl = CTRL_DIV;
          o_kind = MC_DIV;
        end
        FUNC_NOP:  o_ctrl = CTRL_NOP;
        default: begin
          o_ctrl    = CTRL_NOP;
          o_illegal = 1'b1;
        end
      endcase
    end else begin
      o_ctrl    = CTRL_NOP;
      o_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered, handshaked ALU control decoder.
// Accepts an (alu_op, func_code) pair on in_valid/in_ready and presents the
// ALU control word on out_valid/out_ready after one register stage. MUL and
// DIV are held in a WAIT state for a programmable number of cycles so the
// ALU sees a stable control word for the whole operation.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : upstream handshake
//   alu_op, func_code     : main-control op and R-type function field
//   out_valid / out_ready : downstream handshake to the ALU
//   alu_ctrl, illegal     : registered control word and unknown-func flag
//   busy                  : multi-cycle operation in progress
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned        OP_W       = 4,
  parameter int unsigned        FUNC_W     = 6,
  parameter int unsigned        CTRL_W     = 4,
  parameter logic [OP_W-1:0]    RTYPE_OP   = OP_W'(4'b1111),
  parameter int unsigned        MUL_CYCLES = 4,
  parameter int unsigned        DIV_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [FUNC_W-1:0] func_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              busy,
  output logic              illegal
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(MAX_CYC);
  localparam logic [CTRL_W-1:0] CTRL_NOP_W = CTRL_W'(CTRL_NOP);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CTRL_W-1:0]   r_ctrl;
  logic                r_illegal;
  logic                r_out_valid;
  logic                r_busy;

  state_e              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_load;
  logic                w_accept;
  logic                w_in_ready;

  logic [3:0]          w_dec_ctrl;
  logic                w_dec_ill;
  mc_kind_e            w_dec_kind;

  logic [CTRL_W-1:0]   w_ctrl_next;
  logic                w_ill_next;
  mc_kind_e            w_kind_next;
  logic [CNT_W-1:0]    w_load_cnt;
  state_e              w_load_state;

  alu_func_decode #(
    .FUNC_W (FUNC_W)
  ) u_func_decode (
    .i_func    (func_code),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_dec_ill),
    .o_kind    (w_dec_kind)
  );

  // Select between R-type function decoding and direct pass-through of alu_op.
  always_comb begin
    w_ctrl_next = '0;
    w_ill_next  = 1'b0;
    w_kind_next = MC_NONE;
    if (alu_op == RTYPE_OP) begin
      w_ctrl_next[3:0] = w_dec_ctrl;
      w_ill_next       = w_dec_ill;
      w_kind_next      = w_dec_kind;
    end else begin
      w_ctrl_next[3:0] = alu_op[3:0];
    end
  end

  // Counter preload and destination state for a newly accepted op; a zero
  // preload (cycle count of 1) skips WAIT entirely.
  always_comb begin
    w_load_cnt = '0;
    case (w_kind_next)
      MC_MUL:  w_load_cnt = CNT_W'(MUL_CYCLES - 1);
      MC_DIV:  w_load_cnt = CNT_W'(DIV_CYCLES - 1);
      default: w_load_cnt = '0;
    endcase
    if (w_load_cnt == '0) begin
      w_load_state = ST_OUT;
    end else begin
      w_load_state = ST_WAIT;
    end
  end

  // OUT may accept in the same cycle its held result is consumed.
  assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_OUT) && out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // Next-state logic of the control FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = w_load_state;
          w_cnt_nxt   = w_load_cnt;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Leave WAIT on the count of one so OUT lands exactly N cycles after accept.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_OUT;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (w_accept) begin
            w_load      = 1'b1;
            w_state_nxt = w_load_state;
            w_cnt_nxt   = w_load_cnt;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and output registers; control word only moves on a load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ctrl      <= CTRL_NOP_W;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_state_nxt == ST_OUT);
      r_busy      <= (w_state_nxt == ST_WAIT);
      if (w_load) begin
        r_ctrl    <= w_ctrl_next;
        r_illegal <= w_ill_next;
      end else begin
        r_ctrl    <= r_ctrl;
        r_illegal <= r_illegal;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign alu_ctrl  = r_ctrl;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed vectors with literal
// expectations plus a transaction-level model compared on every cycle.
module tb_alu_ctrl_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] alu_op;
  logic [5:0] func_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_ctrl;
  logic       busy;
  logic       illegal;

  int errors;
  int checks;
  bit chk_en;

  alu_ctrl_pipe #(
    .OP_W       (4),
    .FUNC_W     (6),
    .CTRL_W     (4),
    .RTYPE_OP   (4'b1111),
    .MUL_CYCLES (4),
    .DIV_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .func_code (func_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .busy      (busy),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word straight from the decode table.
  function automatic logic [3:0] exp_ctrl(input logic [3:0] op, input logic [5:0] f);
    if (op != 4'b1111) return op;
    case (f)
      6'b100000: return 4'd0;
      6'b100010: return 4'd1;
      6'b100001: return 4'd2;
      6'b100011: return 4'd3;
      6'b100100: return 4'd4;
      6'b100101: return 4'd5;
      6'b101010: return 4'd6;
      6'b011000: return 4'd7;
      6'b011010: return 4'd8;
      default:   return 4'd15;
    endcase
  endfunction

  function automatic logic exp_ill(input logic [3:0] op, input logic [5:0] f);
    if (op != 4'b1111) return 1'b0;
    case (f)
      6'b100000, 6'b100010, 6'b100001, 6'b100011, 6'b100100,
      6'b100101, 6'b101010, 6'b011000, 6'b011010, 6'b000000: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Cycles from accept edge to the first cycle with out_valid.
  function automatic int latency(input logic [3:0] op, input logic [5:0] f);
    if (op == 4'b1111 && f == 6'b011000) return 4;
    if (op == 4'b1111 && f == 6'b011010) return 8;
    return 1;
  endfunction

  // Model: at most one op in flight, visible once its latency has elapsed.
  bit       m_have;
  int       m_left;
  logic [3:0] m_ctrl;
  logic     m_ill;
  logic     m_valid;
  logic     m_busy;
  logic     m_in_ready;

  assign m_valid    = m_have && (m_left == 0);
  assign m_busy     = m_have && (m_left > 0);
  assign m_in_ready = !m_have || (m_valid && out_ready);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_have <= 1'b0;
      m_left <= 0;
      m_ctrl <= 4'hF;
      m_ill  <= 1'b0;
    end else if (in_valid && m_in_ready) begin
      m_have <= 1'b1;
      m_left <= latency(alu_op, func_code) - 1;
      m_ctrl <= exp_ctrl(alu_op, func_code);
      m_ill  <= exp_ill(alu_op, func_code);
    end else if (m_valid && out_ready) begin
      m_have <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
        chk("mdl_busy",      32'(busy),      32'(m_busy));
        chk("mdl_in_ready",  32'(in_ready),  32'(m_in_ready));
        chk("mdl_alu_ctrl",  32'(alu_ctrl),  32'(m_ctrl));
        chk("mdl_illegal",   32'(illegal),   32'(m_ill));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] f);
    in_valid  = v;
    alu_op    = op;
    func_code = f;
  endtask

  initial begin
    int n;
    errors    = 0;
    checks    = 0;
    chk_en    = 1'b0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 4'hF, 6'b100000);

    // Reset held two cycles with a request pending.
    step();
    chk_en = 1'b1;
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_ctrl",  32'(alu_ctrl),  32'hF);
    chk("rst_busy",      32'(busy),      32'd0);
    drive(1'b0, 4'hF, 6'b100000);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // SUB then back-to-back ADD/SUB/AND at full rate.
    drive(1'b1, 4'hF, 6'b100010);
    step();
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_ctrl",  32'(alu_ctrl),  32'h1);
    drive(1'b1, 4'hF, 6'b100000);
    step();
    chk("b2b_add", 32'(alu_ctrl), 32'h0);
    drive(1'b1, 4'hF, 6'b100010);
    step();
    chk("b2b_sub", 32'(alu_ctrl), 32'h1);
    drive(1'b1, 4'hF, 6'b100100);
    step();
    chk("b2b_and", 32'(alu_ctrl), 32'h4);
    chk("b2b_and_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 4'h0, 6'b000000);
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Non-R pass-through then illegal function.
    drive(1'b1, 4'b0101, 6'b111111);
    step();
    chk("nonr_ctrl", 32'(alu_ctrl), 32'h5);
    chk("nonr_ill",  32'(illegal),  32'd0);
    drive(1'b1, 4'hF, 6'b111111);
    step();
    chk("ill_ctrl",  32'(alu_ctrl),  32'hF);
    chk("ill_flag",  32'(illegal),   32'd1);
    chk("ill_valid", 32'(out_valid), 32'd1);
    drive(1'b1, 4'hF, 6'b100101);
    step();
    chk("or_ctrl", 32'(alu_ctrl), 32'h5);
    chk("or_ill",  32'(illegal),  32'd0);
    drive(1'b0, 4'h0, 6'b000000);
    step();

    // MUL: three busy cycles, valid in the fourth.
    drive(1'b1, 4'hF, 6'b011000);
    step();
    drive(1'b0, 4'h0, 6'b000000);
    for (int i = 1; i <= 3; i++) begin
      chk("mul_busy",     32'(busy),      32'd1);
      chk("mul_in_ready", 32'(in_ready),  32'd0);
      chk("mul_no_valid", 32'(out_valid), 32'd0);
      chk("mul_ctrl_held", 32'(alu_ctrl), 32'h7);
      step();
    end
    chk("mul_valid", 32'(out_valid), 32'd1);
    chk("mul_ctrl",  32'(alu_ctrl),  32'h7);
    chk("mul_busy_off", 32'(busy),   32'd0);
    step();

    // DIV: out_valid in cycle 8 after accept.
    drive(1'b1, 4'hF, 6'b011010);
    step();
    drive(1'b0, 4'h0, 6'b000000);
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n = n + 1;
    end
    chk("div_latency", 32'(n), 32'd8);
    chk("div_ctrl", 32'(alu_ctrl), 32'h8);
    step();

    // Backpressure after an ADD with a SUB waiting upstream.
    drive(1'b1, 4'hF, 6'b100000);
    step();
    out_ready = 1'b0;
    drive(1'b1, 4'hF, 6'b100010);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ctrl",     32'(alu_ctrl),  32'h0);
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_valid",    32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_sub_ctrl",  32'(alu_ctrl),  32'h1);
    chk("bp_sub_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 4'h0, 6'b000000);
    step();

    // Reset during the second WAIT cycle of a DIV discards it.
    drive(1'b1, 4'hF, 6'b011010);
    step();
    drive(1'b0, 4'h0, 6'b000000);
    step();
    chk("rdiv_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rdiv_busy_off", 32'(busy), 32'd0);
    chk("rdiv_ctrl", 32'(alu_ctrl), 32'hF);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n = n + 1;
      step();
    end
    chk("rdiv_never_valid", 32'(n), 32'd0);

    // Tail: a few mixed ops under intermittent backpressure, model-checked.
    drive(1'b1, 4'hF, 6'b101010);
    step();
    out_ready = 1'b0;
    drive(1'b1, 4'hF, 6'b100011);
    step();
    out_ready = 1'b1;
    step();
    chk("tail_subu", 32'(alu_ctrl), 32'h3);
    drive(1'b1, 4'hF, 6'b100001);
    step();
    chk("tail_addu", 32'(alu_ctrl), 32'h2);
    drive(1'b1, 4'hF, 6'b000000);
    step();
    chk("tail_nop_ctrl", 32'(alu_ctrl), 32'hF);
    chk("tail_nop_ill",  32'(illegal),  32'd0);
    drive(1'b0, 4'h0, 6'b000000);
    step();
    step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
